// File: rtl/pio_pkg.sv
// Shared definitions for the TX FIFO / OSR pull controller.
// Holds the default FIFO depth, the pull FSM state type and threshold decode.
package pio_pkg;

   localparam int unsigned PIO_TX_DEPTH = 4;
   localparam logic [5:0]  THRESH_FULL  = 6'd32;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } pull_state_e;

   // A programmed threshold of zero stands for a full 32-bit word.
   function automatic logic [5:0] decode_thresh(input logic [4:0] thresh);
      logic [5:0] thr;
      if (thresh == 5'd0) begin
         thr = THRESH_FULL;
      end else begin
         thr = {1'b0, thresh};
      end
      return thr;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous word FIFO with run-time capacity, flush and a sticky overflow flag.
// Capacity may be any power of two up to MAX_DEPTH; pointers wrap at the active capacity.
module sync_fifo
   import pio_pkg::*;
#(
   parameter  int unsigned DEPTH     = PIO_TX_DEPTH,
   parameter  int unsigned MAX_DEPTH = DEPTH,
   localparam int unsigned AW        = $clog2(MAX_DEPTH),
   localparam int unsigned LW        = AW + 1
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic [LW-1:0] cap,
   input  logic          push,
   input  logic [31:0]   din,
   input  logic          pop,
   input  logic          clr_overflow,
   output logic [31:0]   dout,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level,
   output logic          overflow
);

   logic [31:0]   mem_r [MAX_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [LW-1:0] level_r;
   logic          overflow_r;
   logic          full_s;
   logic          empty_s;
   logic          pop_s;
   logic          push_s;
   logic          ovf_evt_s;
   logic [AW-1:0] wr_ptr_nxt_s;
   logic [AW-1:0] rd_ptr_nxt_s;

   assign full_s  = (level_r == cap);
   assign empty_s = (level_r == LW'(0));

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign pop_s     = pop && !empty_s && !flush;
   assign push_s    = push && (!full_s || pop_s) && !flush;
   assign ovf_evt_s = push && full_s && !pop_s && !flush;

   assign wr_ptr_nxt_s = ({1'b0, wr_ptr_r} == (cap - LW'(1))) ? AW'(0) : (wr_ptr_r + AW'(1));
   assign rd_ptr_nxt_s = ({1'b0, rd_ptr_r} == (cap - LW'(1))) ? AW'(0) : (rd_ptr_r + AW'(1));

   // Storage array: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         level_r  <= LW'(0);
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_nxt_s;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_nxt_s;
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Sticky overflow; a new overflow event wins over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= ovf_evt_s | (overflow_r & ~clr_overflow);
      end
   end

   assign dout     = mem_r[rd_ptr_r];
   assign full     = full_s;
   assign empty    = empty_s;
   assign level    = level_r;
   assign overflow = overflow_r;

endmodule

// File: rtl/osr_pull_ctrl.sv
// TX FIFO plus PULL / autopull controller feeding the OSR shifter load port.
// Optional TX_FIFO_JOIN_EN adds fjoin, doubling FIFO depth and widening level by one bit.
module osr_pull_ctrl
   import pio_pkg::*;
#(
   parameter  int unsigned DEPTH     = PIO_TX_DEPTH,
`ifdef TX_FIFO_JOIN_EN
   localparam int unsigned MAX_DEPTH = 2 * DEPTH,
`else
   localparam int unsigned MAX_DEPTH = DEPTH,
`endif
   localparam int unsigned LW        = $clog2(MAX_DEPTH) + 1
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          penable,
   input  logic          push,
   input  logic [31:0]   din,
   input  logic          clr_overflow,
   input  logic          pull_req,
   input  logic          pull_block,
   input  logic          pull_ifempty,
   input  logic          auto_pull,
   input  logic [4:0]    pull_thresh,
   input  logic [5:0]    shift_count,
   input  logic [31:0]   x_val,
`ifdef TX_FIFO_JOIN_EN
   input  logic          fjoin,
`endif
   output logic          osr_set,
   output logic [31:0]   osr_din,
   output logic [5:0]    osr_bit_count,
   output logic          stall,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level,
   output logic          overflow
);

   pull_state_e   state_r;
   pull_state_e   state_nxt_s;
   logic          flush_s;
   logic [LW-1:0] cap_s;
   logic [31:0]   fifo_dout_s;
   logic          fifo_empty_s;
   logic          avail_s;
   logic          at_thr_s;
   logic          pop_s;
   logic          load_s;
   logic          load_x_s;
   logic          stall_s;

`ifdef TX_FIFO_JOIN_EN
   logic          fjoin_r;

   // Remember the join setting so a change can flush the FIFO.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fjoin_r <= 1'b0;
      end else begin
         fjoin_r <= fjoin;
      end
   end

   assign flush_s = (fjoin != fjoin_r);
   assign cap_s   = fjoin ? LW'(MAX_DEPTH) : LW'(DEPTH);
`else
   assign flush_s = 1'b0;
   assign cap_s   = LW'(DEPTH);
`endif

   sync_fifo #(
      .DEPTH     (DEPTH),
      .MAX_DEPTH (MAX_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush        (flush_s),
      .cap          (cap_s),
      .push         (push),
      .din          (din),
      .pop          (pop_s),
      .clr_overflow (clr_overflow),
      .dout         (fifo_dout_s),
      .full         (full),
      .empty        (fifo_empty_s),
      .level        (level),
      .overflow     (overflow)
   );

   assign avail_s  = !fifo_empty_s && !flush_s;
   assign at_thr_s = (shift_count >= decode_thresh(pull_thresh));

   // Pull FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state, pop and load decisions; explicit PULL outranks autopull.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      load_s      = 1'b0;
      load_x_s    = 1'b0;
      stall_s     = 1'b0;
      if (!reset_n) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (penable && pull_req) begin
                  if (pull_ifempty && !at_thr_s) begin
                     state_nxt_s = IDLE;
                  end else if (avail_s) begin
                     pop_s  = 1'b1;
                     load_s = 1'b1;
                  end else if (pull_block) begin
                     stall_s     = 1'b1;
                     state_nxt_s = WAIT;
                  end else begin
                     load_s   = 1'b1;
                     load_x_s = 1'b1;
                  end
               end else if (penable && auto_pull && at_thr_s) begin
                  if (avail_s) begin
                     pop_s  = 1'b1;
                     load_s = 1'b1;
                  end else begin
                     stall_s = 1'b1;
                  end
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            WAIT: begin
               if (!penable || !pull_req) begin
                  state_nxt_s = IDLE;
               end else if (avail_s) begin
                  pop_s       = 1'b1;
                  load_s      = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  stall_s = 1'b1;
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   assign osr_set       = load_s;
   assign osr_din       = load_s ? (load_x_s ? x_val : fifo_dout_s) : 32'd0;
   assign osr_bit_count = 6'd0;
   assign stall         = stall_s;
   assign empty         = fifo_empty_s;

endmodule
